// File: rtl/ram_banked_nxm_pkg.sv
// ram_banked_nxm_pkg: definitions shared by the banked RAM slice.
//   - state_e    : sweep/serve FSM encodings (ST_IDLE, ST_CLEAR)
//   - RW_WRITE / RW_READ : encodings of the rw request bit
//   - even_parity: even-parity helper used by the lanes when RAM_PARITY_EN is defined
package ram_banked_nxm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Even parity of a lane value. Callers zero-extend narrower lanes,
  // which leaves the parity unchanged.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_banked_nxm_if.sv
// ram_banked_nxm_if: request/response bundle of the banked RAM.
//   master drives : req, rw, be, addr, data_in
//   slave drives  : data_out, valid, busy, parity_err (parity_err only with RAM_PARITY_EN)
// Optional feature macro: RAM_PARITY_EN
interface ram_banked_nxm_if #(
  parameter int BANK_W = 8,
  parameter int BANKS  = 2,
  parameter int ADDR_W = 2
) ();
  localparam int W = BANKS * BANK_W;

  logic              req;
  logic              rw;
  logic [BANKS-1:0]  be;
  logic [ADDR_W-1:0] addr;
  logic [W-1:0]      data_in;
  logic [W-1:0]      data_out;
  logic              valid;
  logic              busy;
`ifdef RAM_PARITY_EN
  logic [BANKS-1:0]  parity_err;

  modport master (output req, rw, be, addr, data_in,
                  input  data_out, valid, busy, parity_err);
  modport slave  (input  req, rw, be, addr, data_in,
                  output data_out, valid, busy, parity_err);
`else
  modport master (output req, rw, be, addr, data_in,
                  input  data_out, valid, busy);
  modport slave  (input  req, rw, be, addr, data_in,
                  output data_out, valid, busy);
`endif
endinterface

// File: rtl/ram_banked_nxm_lane.sv
// ram_banked_nxm_lane: one BANK_W-bit (+ optional parity bit) x DEPTH lane array.
//   i_clk   : clock
//   i_clr   : synchronous active-high clear of the read registers (array untouched)
//   i_we    : write i_wdata to i_addr
//   i_re    : register the word at i_addr onto o_rdata (and o_perr)
//   i_addr  : word address
//   i_wdata : lane write data
//   o_rdata : registered read data, holds between reads
//   o_perr  : registered parity mismatch of the last read (RAM_PARITY_EN only)
// Optional feature macro: RAM_PARITY_EN
module ram_banked_nxm_lane
  import ram_banked_nxm_pkg::*;
#(
  parameter int BANK_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [BANK_W-1:0] i_wdata,
`ifdef RAM_PARITY_EN
  output logic              o_perr,
`endif
  output logic [BANK_W-1:0] o_rdata
);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = BANK_W + 1;   // parity kept in the top bit
`else
  localparam int MEM_W = BANK_W;
`endif

  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic [MEM_W-1:0]  w_entry;
  logic [BANK_W-1:0] r_rdata;

`ifdef RAM_PARITY_EN
  logic r_perr;
  // Stored entry: even parity of the data above the data bits.
  always_comb begin
    w_entry = {even_parity(64'(i_wdata)), i_wdata};
  end
`else
  // Stored entry is the plain lane data.
  always_comb begin
    w_entry = i_wdata;
  end
`endif

  // Array write port; contents are not reset (the clear sweep zeroes them).
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= w_entry;
    end
  end

  // Registered read port; clr discards any read in flight.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_rdata <= '0;
`ifdef RAM_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr][BANK_W-1:0];
`ifdef RAM_PARITY_EN
      r_perr  <= r_mem[i_addr][BANK_W] ^ even_parity(64'(r_mem[i_addr][BANK_W-1:0]));
`endif
    end
  end

  assign o_rdata = r_rdata;
`ifdef RAM_PARITY_EN
  assign o_perr  = r_perr;
`endif

endmodule

// File: rtl/ram_banked_nxm.sv
// ram_banked_nxm: single-port synchronous RAM of BANKS byte lanes with per-lane
// write enables, a 1-cycle registered read with valid strobe and a sequenced
// clear sweep (one word per cycle while busy).
//   i_clk : clock, all state changes on the rising edge
//   i_clr : synchronous active-high reset; also (re)starts the clear sweep
//   bus   : ram_banked_nxm_if.slave (req/rw/be/addr/data_in in,
//           data_out/valid/busy[/parity_err] out)
// Optional feature macro: RAM_PARITY_EN (per-lane even parity + parity_err)
module ram_banked_nxm
  import ram_banked_nxm_pkg::*;
#(
  parameter int BANK_W = 8,
  parameter int BANKS  = 2,
  parameter int ADDR_W = 2
) (
  input  logic             i_clk,
  input  logic             i_clr,
  ram_banked_nxm_if.slave  bus
);
  localparam int W = BANKS * BANK_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  state_e            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_valid;
  logic              r_busy;

  logic              w_sweep;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [BANKS-1:0]  w_we;
  logic [W-1:0]      w_wdata;
  logic [W-1:0]      w_rdata;
`ifdef RAM_PARITY_EN
  logic [BANKS-1:0]  w_perr;
`endif

  // Request qualification: an edge with clr high accepts nothing.
  always_comb begin
    w_sweep = (r_state == ST_CLEAR) && !i_clr;
    w_rd    = (r_state == ST_IDLE) && bus.req && !i_clr && (bus.rw == RW_READ);
    w_wr    = (r_state == ST_IDLE) && bus.req && !i_clr && (bus.rw == RW_WRITE);
  end

  // Lane address/write mux: the sweep owns the array while clearing.
  always_comb begin
    if (w_sweep) begin
      w_addr  = r_ptr;
      w_we    = {BANKS{1'b1}};
      w_wdata = '0;
    end else begin
      w_addr  = bus.addr;
      w_we    = w_wr ? bus.be : {BANKS{1'b0}};
      w_wdata = bus.data_in;
    end
  end

  // Control FSM: sweep pointer, busy and read valid strobe.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_valid <= 1'b0;
          r_ptr   <= r_ptr + ADDR_W'(1);
          if (r_ptr == PTR_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
          end
        end
        ST_IDLE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= w_rd;
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < BANKS; i++) begin : g_lane
    ram_banked_nxm_lane #(
      .BANK_W (BANK_W),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .i_clk   (i_clk),
      .i_clr   (i_clr),
      .i_we    (w_we[i]),
      .i_re    (w_rd),
      .i_addr  (w_addr),
      .i_wdata (w_wdata[i*BANK_W +: BANK_W]),
`ifdef RAM_PARITY_EN
      .o_perr  (w_perr[i]),
`endif
      .o_rdata (w_rdata[i*BANK_W +: BANK_W])
    );
  end

  assign bus.data_out = w_rdata;
  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;
`ifdef RAM_PARITY_EN
  assign bus.parity_err = w_perr;
`endif

endmodule

// File: tb/tb_ram_banked_nxm.sv
// tb_ram_banked_nxm: directed self-checking bench for ram_banked_nxm
// (BANK_W=8, BANKS=2, ADDR_W=2). Optional macro: RAM_PARITY_EN.
module tb_ram_banked_nxm;
  logic clk;
  logic clr;
  int   n_total;
  int   n_bad;
  logic [15:0] last_q;   // expected held value of data_out

  ram_banked_nxm_if #(.BANK_W(8), .BANKS(2), .ADDR_W(2)) bus ();

  ram_banked_nxm #(.BANK_W(8), .BANKS(2), .ADDR_W(2)) dut (
    .i_clk (clk),
    .i_clr (clr),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] be, input logic [15:0] d, input string tag);
    bus.req = 1'b1; bus.rw = 1'b1; bus.addr = a; bus.be = be; bus.data_in = d;
    step();
    bus.req = 1'b0;
    chk({tag, "_wr_valid"}, 32'(bus.valid), 32'd0);
    chk({tag, "_wr_hold"}, 32'(bus.data_out), 32'(last_q));
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
    bus.req = 1'b1; bus.rw = 1'b0; bus.addr = a;
    step();
    bus.req = 1'b0;
    chk({tag, "_valid"}, 32'(bus.valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.data_out), 32'(exp));
    last_q = exp;
    step();
    chk({tag, "_valid_drop"}, 32'(bus.valid), 32'd0);
    chk({tag, "_hold"}, 32'(bus.data_out), 32'(exp));
  endtask

  // clr for one edge, then expect busy for exactly 4 edges total.
  task automatic clear_seq(input string tag);
    clr = 1'b1;
    step();
    clr = 1'b0;
    last_q = 16'h0000;
    chk({tag, "_rst_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_rst_valid"}, 32'(bus.valid), 32'd0);
    chk({tag, "_rst_dout"}, 32'(bus.data_out), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk({tag, "_busy_hi"}, 32'(bus.busy), 32'd1);
    end
    step();
    chk({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    last_q  = 16'h0000;
    clr = 1'b1;
    bus.req = 1'b0; bus.rw = 1'b0; bus.be = 2'b00; bus.addr = 2'd0; bus.data_in = 16'h0000;

    // 1: clear timing and cleared contents, back-to-back reads
    clear_seq("t1");
    for (int a = 0; a < 4; a++) begin
      bus.req = 1'b1; bus.rw = 1'b0; bus.addr = 2'(a);
      step();
      chk("t1_b2b_valid", 32'(bus.valid), 32'd1);
      chk("t1_b2b_data", 32'(bus.data_out), 32'h0000);
    end
    bus.req = 1'b0;
    step();
    chk("t1_valid_end", 32'(bus.valid), 32'd0);

    // 2: read path
    wr(2'd2, 2'b11, 16'hBEEF, "t2");
    rd(2'd2, 16'hBEEF, "t2");

    // 3: lane enables
    clear_seq("t3");
    wr(2'd1, 2'b01, 16'h1234, "t3a");
    rd(2'd1, 16'h0034, "t3a");
    wr(2'd1, 2'b10, 16'hAB00, "t3b");
    rd(2'd1, 16'hAB34, "t3b");
    wr(2'd1, 2'b00, 16'hFFFF, "t3c");
    rd(2'd1, 16'hAB34, "t3c");

    // 4: restart at ptr=2 and a write dropped while busy
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    last_q = 16'h0000;
    chk("t4_restart_busy", 32'(bus.busy), 32'd1);
    bus.req = 1'b1; bus.rw = 1'b1; bus.addr = 2'd3; bus.be = 2'b11; bus.data_in = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_busy_hi", 32'(bus.busy), 32'd1);
    end
    bus.req = 1'b0;
    step();
    chk("t4_busy_lo", 32'(bus.busy), 32'd0);
    rd(2'd3, 16'h0000, "t4");

    // 5: clr on a read-accepting edge discards it
    wr(2'd2, 2'b11, 16'hBEEF, "t5");
    rd(2'd2, 16'hBEEF, "t5pre");
    bus.req = 1'b1; bus.rw = 1'b0; bus.addr = 2'd2;
    clr = 1'b1;
    step();
    clr = 1'b0;
    bus.req = 1'b0;
    last_q = 16'h0000;
    chk("t5_clr_valid", 32'(bus.valid), 32'd0);
    chk("t5_clr_dout", 32'(bus.data_out), 32'h0000);
    chk("t5_clr_busy", 32'(bus.busy), 32'd1);
    for (int k = 0; k < 4; k++) step();
    chk("t5_busy_lo", 32'(bus.busy), 32'd0);
    wr(2'd0, 2'b11, 16'h5A5A, "t5");
    rd(2'd0, 16'h5A5A, "t5");

`ifdef RAM_PARITY_EN
    // 6: clean word, then a corrupted bit 3 in lane 0 of word 1
    bus.req = 1'b1; bus.rw = 1'b0; bus.addr = 2'd1;
    step();
    bus.req = 1'b0;
    chk("t6_clean_valid", 32'(bus.valid), 32'd1);
    chk("t6_clean_perr", 32'(bus.parity_err), 32'd0);
    step();
    dut.g_lane[0].u_lane.r_mem[1][3] = ~dut.g_lane[0].u_lane.r_mem[1][3];
    bus.req = 1'b1; bus.rw = 1'b0; bus.addr = 2'd1;
    step();
    bus.req = 1'b0;
    chk("t6_bad_valid", 32'(bus.valid), 32'd1);
    chk("t6_bad_data", 32'(bus.data_out), 32'h0008);
    chk("t6_bad_perr", 32'(bus.parity_err), 32'd1);
    step();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
